// File: rtl/seven_seg_scanner.sv
// Scan controller for a time-multiplexed common-cathode seven-segment display.
// Digit codes are double-buffered; each slot starts with a dark gap so codes never change while lit.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 12000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [4:0]                    wr_data,
    input  logic                          update,
    output logic [7:0]                    digit_code,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_start,
    output logic                          update_pending
);

    localparam int unsigned AW = $clog2(NUM_DIGITS);
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [AW-1:0] LastIdx   = AW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LastCnt   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] LastBlank = CW'(BLANK_CYCLES - 1);
    localparam logic [4:0]    CodeBlank = 5'd31;

    typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d, next_idx;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4:0]            shadow_q [NUM_DIGITS];
    logic [4:0]            shadow_d [NUM_DIGITS];
    logic [4:0]            active_q [NUM_DIGITS];
    logic [4:0]            active_d [NUM_DIGITS];
    logic                  pending_q, pending_d;
    logic [7:0]            code_q, code_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  frame_q, frame_d;
    logic                  slot_edge, frame_edge, commit;

    // Codes 17..31 are blank: present 0 on the decoder bus.
    function automatic logic [7:0] present(input logic [4:0] c);
        return (c < 5'd17) ? {3'b000, c} : 8'h00;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_d[i] = (wr_en && wr_addr == AW'(i)) ? wr_data : shadow_q[i];
        end
    end

    always_comb begin
        slot_edge  = 1'b0;
        frame_edge = 1'b0;
        next_idx   = idx_q;
        if (enable) begin
            case (state_q)
                StBlank: ;
                StOn: begin
                    if (cnt_q == LastCnt) begin
                        slot_edge  = 1'b1;
                        frame_edge = (idx_q == LastIdx);
                        next_idx   = frame_edge ? '0 : idx_q + 1'b1;
                    end
                end
                default: begin
                    slot_edge  = 1'b1;
                    frame_edge = 1'b1;
                    next_idx   = '0;
                end
            endcase
        end

        // Commit sees same-cycle shadow writes so slot 0 shows post-commit values.
        commit    = frame_edge && (pending_q || update);
        pending_d = commit ? 1'b0 : (pending_q || update);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            active_d[i] = commit ? shadow_d[i] : active_q[i];
        end

        state_d = state_q;
        idx_d   = next_idx;
        cnt_d   = cnt_q + 1'b1;
        code_d  = code_q;
        sel_d   = sel_q;
        frame_d = frame_edge;
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
            code_d  = '0;
            sel_d   = '0;
        end else if (slot_edge) begin
            state_d = StBlank;
            cnt_d   = '0;
            code_d  = present(active_d[next_idx]);
            sel_d   = '0;
        end else if (state_q == StBlank && cnt_q == LastBlank) begin
            state_d = StOn;
            sel_d   = (active_q[idx_q] < 5'd17) ? (NUM_DIGITS'(1) << idx_q) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '{default: CodeBlank};
            active_q  <= '{default: CodeBlank};
            pending_q <= 1'b0;
            code_q    <= '0;
            sel_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            sel_q     <= sel_d;
            frame_q   <= frame_d;
        end
    end

    assign digit_code     = code_q;
    assign digit_sel      = sel_q;
    assign frame_start    = frame_q;
    assign update_pending = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a frame-time reference model.
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic       update = 1'b0;
    logic [7:0] digit_code;
    logic [3:0] digit_sel;
    logic       frame_start;
    logic       update_pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time since the enable edge, modulo one frame.
    int m_shadow [N];
    int m_active [N];
    bit m_pending;
    bit m_run;
    int m_t;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .update        (update),
        .digit_code    (digit_code),
        .digit_sel     (digit_sel),
        .frame_start   (frame_start),
        .update_pending(update_pending)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 31;
            m_active[i] = 31;
        end
        m_pending = 1'b0;
        m_run     = 1'b0;
        m_t       = 0;
    endtask

    task automatic model_step();
        bit fe;
        fe = 1'b0;
        if (!enable) begin
            m_run = 1'b0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t = (m_t + 1) % (N * S);
            end
            fe = (m_t == 0);
        end
        if (wr_en && int'(wr_addr) < N) m_shadow[wr_addr] = int'(wr_data);
        if (fe && (m_pending || update)) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end else if (update) begin
            m_pending = 1'b1;
        end
    endtask

    task automatic compare();
        int slot, ph, code, sel, fs;
        bit lit;
        code = 0;
        sel  = 0;
        fs   = 0;
        if (m_run) begin
            slot = m_t / S;
            ph   = m_t % S;
            lit  = (m_active[slot] < 17);
            code = lit ? m_active[slot] : 0;
            sel  = (lit && ph >= B) ? (1 << slot) : 0;
            fs   = (m_t == 0) ? 1 : 0;
        end
        check_eq("digit_code", int'(digit_code), code);
        check_eq("digit_sel", int'(digit_sel), sel);
        check_eq("frame_start", int'(frame_start), fs);
        check_eq("update_pending", int'(update_pending), int'(m_pending));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic wait_t(input int target);
        int k;
        k = 0;
        while (!(m_run && m_t == target) && k < 200) begin
            cycle();
            k++;
        end
        if (k >= 200) check_eq("wait_timeout", k, 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_sel", int'(digit_sel), 0);
        check_eq("rst_async_code", int'(digit_code), 0);
        check_eq("rst_async_fs", int'(frame_start), 0);
        check_eq("rst_async_pend", int'(update_pending), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        compare();

        // All blank after reset.
        enable = 1'b1;
        repeat (70) cycle();

        // Digits 1..4 then commit.
        for (int i = 0; i < N; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_data = 5'(i + 1);
            cycle();
        end
        wr_en  = 1'b0;
        update = 1'b1;
        cycle();
        update = 1'b0;
        repeat (70) cycle();

        // Write + update in the cycle just before a frame start.
        wait_t(N * S - 1);
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = 5'd16;
        update  = 1'b1;
        cycle();
        check_eq("commit_at_edge_pend", int'(update_pending), 0);
        wr_en  = 1'b0;
        update = 1'b0;
        repeat (40) cycle();

        // Blank code on digit 1.
        wr_en   = 1'b1;
        wr_addr = 2'd1;
        wr_data = 5'd20;
        cycle();
        wr_en  = 1'b0;
        update = 1'b1;
        cycle();
        update = 1'b0;
        repeat (70) cycle();

        // Drop enable in cycle 5 of slot 2, then restart.
        wait_t(2 * S + 5);
        enable = 1'b0;
        repeat (6) cycle();
        enable = 1'b1;
        repeat (40) cycle();

        for (int c = 0; c < 2000; c++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31))
                                                  : 5'($urandom_range(0, 15));
            update  = ($urandom_range(0, 15) == 0);
            if (enable) enable = ($urandom_range(0, 199) != 0);
            else enable = ($urandom_range(0, 9) == 0);
            cycle();
        end

        // Reset during a lit phase.
        enable = 1'b1;
        wr_en  = 1'b0;
        update = 1'b1;
        for (int i = 0; i < N; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_data = 5'(i + 5);
            cycle();
        end
        wr_en  = 1'b0;
        update = 1'b0;
        wait_t(S + 3);
        check_eq("pre_rst_sel", int'(digit_sel), 2);
        do_reset();
        compare();
        repeat (70) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
